// File: rtl/int_sched_pkg.sv
// Shared types and constants for the interrupt scheduler and the PC-select path.
package int_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        TAKE   = 2'd2,
        ACTIVE = 2'd3
    } int_state_t;

    // pcSource value forced by the branch-condition generator when int_taken is high.
    localparam logic [2:0] PC_SRC_INT = 3'b100;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/int_sched_if.sv
// Request/enable/pipeline-status bundle between the core and the interrupt scheduler.
interface int_sched_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned CAUSE_W = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0] irq;
    logic [NUM_SRC-1:0] irq_mask;
    logic               mie;
    logic               redirect;
    logic               stall;
    logic               mret;
    logic               int_taken;
    logic [CAUSE_W-1:0] int_cause;
    logic               int_active;
    logic [NUM_SRC-1:0] pending;

    modport master (
        output irq, irq_mask, mie, redirect, stall, mret,
        input  int_taken, int_cause, int_active, pending
    );

    modport slave (
        input  irq, irq_mask, mie, redirect, stall, mret,
        output int_taken, int_cause, int_active, pending
    );
endinterface

// File: rtl/int_prio_arb.sv
// Combinational picker: first set bit of elig searching upward from start, wrapping.
module int_prio_arb
    import int_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned CAUSE_W = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] elig,
    input  logic [CAUSE_W-1:0] start,
    output logic [CAUSE_W-1:0] winner,
    output logic               valid
);

    always_comb begin
        logic [CAUSE_W-1:0] v_idx;
        winner = '0;
        valid  = 1'b0;
        v_idx  = start;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!valid && elig[v_idx]) begin
                valid  = 1'b1;
                winner = v_idx;
            end
            v_idx = CAUSE_W'(wrap_inc(32'(v_idx), NUM_SRC));
        end
    end

endmodule

// File: rtl/int_sched.sv
// Interrupt scheduler: edge capture, masking, arbitration and safe-point issue of int_taken.
// Define INT_SCHED_RR_EN for round-robin arbitration instead of fixed lowest-index priority.
module int_sched
    import int_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned CAUSE_W = $clog2(NUM_SRC)
) (
    input logic       CLK,
    input logic       RST_N,
    int_sched_if.slave bus
);

    int_state_t         r_state;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_irq_q;
    logic [CAUSE_W-1:0] r_cause;
    logic               r_int_taken;
    logic               r_int_active;

    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_clr;
    logic [CAUSE_W-1:0] w_start;
    logic [CAUSE_W-1:0] w_winner;
    logic               w_valid;
    logic               w_req;
    logic               w_safe;

    assign w_elig = r_pending & bus.irq_mask;
    assign w_rise = bus.irq & ~r_irq_q;
    assign w_req  = bus.mie && w_valid;
    assign w_safe = !bus.stall && !bus.redirect;

    always_comb begin
        w_clr = '0;
        if (r_state == TAKE) w_clr[r_cause] = 1'b1;
    end

    // A new edge on the source being cleared keeps its pending bit set.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pending <= '0;
            r_irq_q   <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_irq_q   <= bus.irq;
        end
    end

`ifdef INT_SCHED_RR_EN
    logic [CAUSE_W-1:0] r_last;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_last <= CAUSE_W'(NUM_SRC - 1);
        end else if (r_state == TAKE) begin
            r_last <= r_cause;
        end
    end

    assign w_start = CAUSE_W'(wrap_inc(32'(r_last), NUM_SRC));
`else
    assign w_start = '0;
`endif

    int_prio_arb #(
        .NUM_SRC (NUM_SRC),
        .CAUSE_W (CAUSE_W)
    ) u_arb (
        .elig   (w_elig),
        .start  (w_start),
        .winner (w_winner),
        .valid  (w_valid)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            r_cause      <= '0;
            r_int_taken  <= 1'b0;
            r_int_active <= 1'b0;
        end else begin
            r_int_taken <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_req) r_state <= ARB;
                end
                // Re-arbitrated every cycle so a later higher-priority request can preempt.
                ARB: begin
                    if (!w_req) begin
                        r_state <= IDLE;
                    end else if (w_safe) begin
                        r_cause     <= w_winner;
                        r_int_taken <= 1'b1;
                        r_state     <= TAKE;
                    end
                end
                TAKE: begin
                    r_state      <= ACTIVE;
                    r_int_active <= 1'b1;
                end
                ACTIVE: begin
                    if (bus.mret) begin
                        r_state      <= IDLE;
                        r_int_active <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_int_active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.int_taken  = r_int_taken;
    assign bus.int_cause  = r_cause;
    assign bus.int_active = r_int_active;
    assign bus.pending    = r_pending;

endmodule
